// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access controller: FSM states, access
// size codes, requester ids and the alignment rule.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LS    = 1'b1
  } req_id_t;

  // Reserved size 2'b11 is treated as a fault, like a misaligned address.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester and memory-side signals of the access controller, bundled so the
// controller sees them through the slave modport.
interface mem_access_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_rw;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        mem_mfc;
  logic [31:0] mem_rdata;
  logic        mem_mov;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        if_gnt;
  logic        ls_gnt;
  logic        if_done;
  logic        ls_done;
  logic [31:0] rdata;
  logic        err;

  modport slave (
    input  if_req, if_addr, ls_req, ls_rw, ls_size, ls_addr, ls_wdata,
           mem_mfc, mem_rdata,
    output mem_mov, mem_rw, mem_size, mem_addr, mem_wdata,
           if_gnt, ls_gnt, if_done, ls_done, rdata, err
  );

  modport master (
    output if_req, if_addr, ls_req, ls_rw, ls_size, ls_addr, ls_wdata,
           mem_mfc, mem_rdata,
    input  mem_mov, mem_rw, mem_size, mem_addr, mem_wdata,
           if_gnt, ls_gnt, if_done, ls_done, rdata, err
  );
endinterface

// File: rtl/mem_access_ctrl_arbiter.sv
// Fetch vs load/store priority with an anti-starvation counter: load/store
// wins ties until fetch has been passed over STARVE_LIM times in a row.
module mem_arbiter
  import mem_access_ctrl_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_en,
  input  logic    i_if_req,
  input  logic    i_ls_req,
  output logic    o_gnt_vld,
  output req_id_t o_winner
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] r_starve_cnt;
  logic          w_starved;

  assign w_starved = (r_starve_cnt == SW'(STARVE_LIM));

  always_comb begin
    o_gnt_vld = i_en & (i_if_req | i_ls_req);
    o_winner  = (i_ls_req && !(i_if_req && w_starved)) ? REQ_LS : REQ_FETCH;
  end

  // Only passes over a waiting fetch count; an uncontested ls grant clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (o_gnt_vld) begin
      if (o_winner == REQ_FETCH || !i_if_req) begin
        r_starve_cnt <= '0;
      end else if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates fetch and load/store, checks alignment,
// runs the MOV/MFC handshake with a bounded wait and reports done/err.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tmo_cnt, w_tmo_nxt, w_tmo_inc;
  logic          r_fault;
  req_id_t       r_owner;

  logic          w_arb_en, w_gnt_vld, w_grant, w_misal, w_err_nxt, w_cap;
  req_id_t       w_winner;
  logic [31:0]   w_sel_addr, w_sel_wdata;
  logic          w_sel_rw;
  logic [1:0]    w_sel_size;

  logic          r_mem_mov, r_mem_rw, r_if_gnt, r_ls_gnt, r_if_done, r_ls_done, r_err;
  logic [1:0]    r_mem_size;
  logic [31:0]   r_mem_addr, r_mem_wdata, r_rdata;

  // A faulted grant spends its gnt cycle in IDLE with arbitration frozen.
  assign w_arb_en = (r_state == ST_IDLE) && !r_fault;

  mem_arbiter #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_arb_en),
    .i_if_req  (bus.if_req),
    .i_ls_req  (bus.ls_req),
    .o_gnt_vld (w_gnt_vld),
    .o_winner  (w_winner)
  );

  always_comb begin
    if (w_winner == REQ_FETCH) begin
      w_sel_addr  = bus.if_addr;
      w_sel_rw    = 1'b1;
      w_sel_size  = SZ_WORD;
      w_sel_wdata = '0;
    end else begin
      w_sel_addr  = bus.ls_addr;
      w_sel_rw    = bus.ls_rw;
      w_sel_size  = bus.ls_size;
      w_sel_wdata = bus.ls_wdata;
    end
    w_misal   = is_misaligned(w_sel_size, w_sel_addr[1:0]);
    w_tmo_inc = r_tmo_cnt + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo_cnt;
    w_grant     = 1'b0;
    w_err_nxt   = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_fault) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
        end else if (w_gnt_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = w_misal ? ST_IDLE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.mem_mfc) begin
          w_state_nxt = ST_DONE;
          w_cap       = r_mem_rw;
        end else if (w_tmo_inc == TW'(TIMEOUT)) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmo_nxt   = w_tmo_inc;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_tmo_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmo_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tmo_cnt <= '0;
      r_fault   <= 1'b0;
      r_owner   <= REQ_FETCH;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_fault   <= w_grant & w_misal;
      if (w_grant) r_owner <= w_winner;
    end
  end

  // Every output is a register; done/err/mov are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_mov   <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_size  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_if_done   <= 1'b0;
      r_ls_done   <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_mem_mov <= (w_state_nxt == ST_BUSY);
      r_if_gnt  <= w_grant && (w_winner == REQ_FETCH);
      r_ls_gnt  <= w_grant && (w_winner == REQ_LS);
      r_if_done <= (w_state_nxt == ST_DONE) && (r_owner == REQ_FETCH);
      r_ls_done <= (w_state_nxt == ST_DONE) && (r_owner == REQ_LS);
      r_err     <= (w_state_nxt == ST_DONE) && w_err_nxt;
      if (w_grant) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_rw    <= w_sel_rw;
        r_mem_size  <= w_sel_size;
        r_mem_wdata <= w_sel_wdata;
      end
      if (w_cap) r_rdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_mov   = r_mem_mov;
  assign bus.mem_rw    = r_mem_rw;
  assign bus.mem_size  = r_mem_size;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_gnt    = r_if_gnt;
  assign bus.ls_gnt    = r_ls_gnt;
  assign bus.if_done   = r_if_done;
  assign bus.ls_done   = r_ls_done;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the single-ported memory behind the control unit's MOV/MFC handshake.
- Arbitrates between the instruction-fetch requester and the load/store requester, with anti-starvation for fetch.
- Checks alignment and drives the memory handshake.
- Enforces a bounded wait on MFC and reports errors to the control unit.

Parameters:
- STARVE_LIM, 4: consecutive load/store grants allowed while fetch waits; the next arbitration then goes to fetch.
- TIMEOUT, 15: BUSY cycles without MFC before the access is aborted with error.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  32  fetch address; word access.
- ls_req  in  1  load/store request; held until ls_done.
- ls_rw  in  1  1=read, 0=write.
- ls_size  in  2  00=byte, 01=half, 10=word, 11=reserved.
- ls_addr  in  32  load/store address.
- ls_wdata  in  32  store data.
- mem_mfc  in  1  memory function complete.
- mem_rdata  in  32  memory read data; valid when mem_mfc=1.
- mem_mov  out  1  memory operation valid.
- mem_rw  out  1  1=read.
- mem_size  out  2  access size.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched store data.
- if_gnt / ls_gnt  out  1 each  one-cycle grant pulse.
- if_done / ls_done  out  1 each  one-cycle completion pulse.
- rdata  out  32  read data; valid with done, held until the next read completes.
- err  out  1  high with done when the access was aborted: misaligned, reserved size, or timeout.

Behaviour:
- Reset (async, rst=1): state IDLE; starve counter 0; timeout counter 0; all outputs 0. A reset mid-access drops mem_mov immediately, and the access is lost without done.
- FSM states: IDLE, BUSY, DONE.
- IDLE, arbitration on each posedge:
  - Only one request: grant it.
  - Both requests: grant ls, unless starve_cnt == STARVE_LIM, then grant fetch.
  - starve_cnt increments on an ls grant while if_req=1, saturating at STARVE_LIM. It clears on any fetch grant, and when ls is granted while if_req=0.
- On grant:
  - Latch addr, rw, size, wdata into mem_* registers. Fetch uses rw=1, size=10.
  - Pulse the matching gnt for the first BUSY cycle.
- Alignment check, done at grant: half with addr[0]=1, word with addr[1:0]!=00, or size 11.
  - Skip BUSY and go directly to DONE with err=1.
  - mem_mov is never raised.
- BUSY:
  - mem_mov=1 every cycle; tmo_cnt increments.
  - mem_mfc=1 at posedge: capture mem_rdata into rdata when reading, go to DONE, err=0.
  - tmo_cnt reaches TIMEOUT without mfc: go to DONE with err=1; rdata unchanged.
  - mfc in the same cycle as the timeout: mfc wins, err=0.
- DONE: exactly one cycle.
  - The owner's done pulse is high; err is valid; mem_mov=0; tmo_cnt cleared.
  - Next state is IDLE, which has no grant bubble beyond one cycle.
- Minimum latency, with mfc held high: request sampled at edge 0; BUSY in cycle 1; DONE in cycle 2; next grant possible at edge 3.
- A requester deasserting req during BUSY does not abort the access; done is still produced.
- mem_mfc outside BUSY is ignored.
- The mem_addr, mem_rw, mem_size, mem_wdata registers keep their latched values through DONE. They reload only on the next grant.
- All outputs are registered; nothing combinational from inputs reaches outputs.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - size codes: BYTE=2'b00, HALF=2'b01, WORD=2'b10;
  - requester id: FETCH=0, LS=1.
- One natural sub-module: mem_arbiter. It is the combinational priority logic plus the starve counter register, outputs the winner id and a grant-valid flag, and is instantiated once.

Test Plan:
- Fetch only: if_addr=0x100, mfc high 2 cycles after mov → if_gnt at cycle 1, mem_addr=0x100, mem_rw=1, size=10; if_done at cycle 4; rdata=mem_rdata (0xE3A00001); err=0.
- Both requesting continuously, mfc immediate:
  - grant order is LS,LS,LS,LS,FETCH,LS…;
  - starve_cnt returns to 0 after the fetch grant.
- Misaligned: ls_size=01, ls_addr=0x103 → ls_gnt then ls_done the next cycle with err=1; mem_mov stays 0 throughout.
- Timeout: mfc never asserted → mem_mov high exactly 15 cycles, then ls_done with err=1, rdata unchanged. Repeat with mfc arriving in cycle 15 → err=0.
- Store: ls_rw=0, size=10, addr=0x200, wdata=0xDEADBEEF → mem_wdata=0xDEADBEEF, mem_rw=0 during BUSY; ls_done on completion; rdata unchanged.
- Reset mid-BUSY: assert rst in the 2nd BUSY cycle → mem_mov falls without a clock edge; no done pulse; after release, a pending if_req is granted from IDLE normally.
